// File: rtl/core_task_receiver.sv
// core_task_receiver: per-core receiving end of the task-dispatch interface.
// Accepts a 256-bit instruction block plus an optional R0 initial value when
// Start is pulsed, streams the block into local instruction memory, optionally
// writes R0, launches the core and waits for Core_Done.
// Optional feature macro: TASK_RX_PROTO_CHECK_EN enables the sticky Proto_Err
// checker. When it is undefined, Proto_Err is tied to 0.
// All outputs are registered.
module core_task_receiver #(
  parameter int unsigned INSN_WIDTH    = 16,
  parameter int unsigned INSN_PER_TASK = 16,
  parameter int unsigned R0_WIDTH      = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                Start,
  input  logic [INSN_WIDTH*INSN_PER_TASK-1:0] Insn_Data,
  input  logic                                Init_R0_Vect,
  input  logic [R0_WIDTH-1:0]                 Init_R0,
  output logic                                Ready,
  output logic                                Imem_We,
  output logic [$clog2(INSN_PER_TASK)-1:0]    Imem_Addr,
  output logic [INSN_WIDTH-1:0]               Imem_Wdata,
  output logic                                R0_We,
  output logic [R0_WIDTH-1:0]                 R0_Wdata,
  output logic                                Core_Go,
  input  logic                                Core_Done,
  output logic                                Proto_Err
);

  localparam int unsigned AW = $clog2(INSN_PER_TASK);
  localparam int unsigned BW = INSN_WIDTH * INSN_PER_TASK;

  localparam logic [AW-1:0] CNT_ONE  = AW'(1);
  localparam logic [AW-1:0] CNT_LAST = AW'(INSN_PER_TASK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_GO   = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         blk_q;
  logic                  vect_q;
  logic [R0_WIDTH-1:0]   r0_q;

  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [INSN_WIDTH-1:0] wdata_q, wdata_d;
  logic                  r0we_q, r0we_d;
  logic [R0_WIDTH-1:0]   r0data_q, r0data_d;
  logic                  go_q, go_d;

  logic                  accept;

  assign accept = (state_q == S_IDLE) && Start;

  // Next-state and word-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_GO;
          cnt_d   = '0;
        end
      end
      S_GO:    state_d = S_WAIT;
      S_WAIT:  if (Core_Done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output pre-decode; every output is taken from a register the cycle after
  // the state that produces it, so Imem_We trails the LOAD state by one cycle.
  always_comb begin
    we_d     = (state_q == S_LOAD);
    addr_d   = '0;
    wdata_d  = '0;
    r0we_d   = 1'b0;
    r0data_d = '0;
    if (we_d) begin
      addr_d  = cnt_q;
      wdata_d = blk_q[cnt_q*INSN_WIDTH +: INSN_WIDTH];
      if (cnt_q == '0) begin
        r0we_d   = vect_q;
        r0data_d = r0_q;
      end
    end
    go_d    = (state_q == S_GO);
    ready_d = (state_d == S_IDLE);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      r0we_q   <= 1'b0;
      r0data_q <= '0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      r0we_q   <= r0we_d;
      r0data_q <= r0data_d;
      go_q     <= go_d;
    end
  end

  // Task latch: captured only when a dispatch is accepted in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_q  <= '0;
      vect_q <= 1'b0;
      r0_q   <= '0;
    end else if (accept) begin
      blk_q  <= Insn_Data;
      vect_q <= Init_R0_Vect;
      r0_q   <= Init_R0;
    end
  end

`ifdef TASK_RX_PROTO_CHECK_EN
  logic err_q;

  // Sticky protocol error: dispatch while busy, or completion before WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if ((Start && (state_q != S_IDLE)) ||
                 (Core_Done && ((state_q == S_LOAD) || (state_q == S_GO)))) begin
      err_q <= 1'b1;
    end
  end

  assign Proto_Err = err_q;
`else
  assign Proto_Err = 1'b0;
`endif

  assign Ready      = ready_q;
  assign Imem_We    = we_q;
  assign Imem_Addr  = addr_q;
  assign Imem_Wdata = wdata_q;
  assign R0_We      = r0we_q;
  assign R0_Wdata   = r0data_q;
  assign Core_Go    = go_q;

endmodule

// File: tb/tb_core_task_receiver.sv
// Testbench for core_task_receiver: directed vector table, hand-written
// corner sequences and randomized traffic against a timeline model.
module tb_core_task_receiver;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic [255:0] Insn_Data;
  logic         Init_R0_Vect;
  logic [15:0]  Init_R0;
  logic         Ready;
  logic         Imem_We;
  logic [3:0]   Imem_Addr;
  logic [15:0]  Imem_Wdata;
  logic         R0_We;
  logic [15:0]  R0_Wdata;
  logic         Core_Go;
  logic         Core_Done;
  logic         Proto_Err;

  int n_checks = 0;
  int n_fail   = 0;

  core_task_receiver #(
    .INSN_WIDTH   (16),
    .INSN_PER_TASK(16),
    .R0_WIDTH     (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Start       (Start),
    .Insn_Data   (Insn_Data),
    .Init_R0_Vect(Init_R0_Vect),
    .Init_R0     (Init_R0),
    .Ready       (Ready),
    .Imem_We     (Imem_We),
    .Imem_Addr   (Imem_Addr),
    .Imem_Wdata  (Imem_Wdata),
    .R0_We       (R0_We),
    .R0_Wdata    (R0_Wdata),
    .Core_Go     (Core_Go),
    .Core_Done   (Core_Done),
    .Proto_Err   (Proto_Err)
  );

  always #5 clk = ~clk;

  // ---------------- timeline reference model ----------------
  // A task accepted at edge t0 writes word k-1 after edge t0+k (k=1..16),
  // launches after edge t0+17 and may complete from edge t0+18 onward.
  int          m_edge = 0;
  bit          m_busy = 0;
  int          m_t0   = 0;
  logic [15:0] m_words[16];
  logic        m_vect;
  logic [15:0] m_r0;
  bit          m_err  = 0;

  logic        e_ready, e_we, e_r0we, e_go, e_err;
  logic [3:0]  e_addr;
  logic [15:0] e_wdata, e_r0data;

  function automatic logic [255:0] make_block(input logic [15:0] base);
    logic [255:0] b;
    for (int k = 0; k < 16; k++) b[16*k +: 16] = base + 16'(k);
    return b;
  endfunction

  task automatic model_step();
    int  k;
    bit  was_busy;
    m_edge++;
    e_we = 0; e_r0we = 0; e_go = 0; e_addr = '0; e_wdata = '0; e_r0data = '0;
    if (!reset) begin
      m_busy  = 0;
      m_err   = 0;
      e_ready = 1;
      e_err   = 0;
      return;
    end
    was_busy = m_busy;
    k = m_edge - m_t0;
    if (was_busy && Start) m_err = 1;
    if (was_busy && Core_Done && k >= 1 && k <= 17) m_err = 1;
    if (was_busy && Core_Done && k >= 18) m_busy = 0;
    if (!was_busy && Start) begin
      m_busy = 1;
      m_t0   = m_edge;
      for (int w = 0; w < 16; w++) m_words[w] = Insn_Data[16*w +: 16];
      m_vect = Init_R0_Vect;
      m_r0   = Init_R0;
    end
    k = m_edge - m_t0;
    if (m_busy) begin
      if (k >= 1 && k <= 16) begin
        e_we    = 1;
        e_addr  = 4'(k - 1);
        e_wdata = m_words[k-1];
      end
      if (k == 1) begin
        e_r0we   = m_vect;
        e_r0data = m_r0;
      end
      e_go = (k == 17);
    end
    e_ready = !m_busy;
`ifdef TASK_RX_PROTO_CHECK_EN
    e_err = m_err;
`else
    e_err = 0;
`endif
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("ready", Ready, e_ready);
    chk("imem_we", Imem_We, e_we);
    if (e_we) begin
      chk("imem_addr", Imem_Addr, e_addr);
      chk("imem_wdata", Imem_Wdata, e_wdata);
    end
    chk("r0_we", R0_We, e_r0we);
    if (e_r0we) chk("r0_wdata", R0_Wdata, e_r0data);
    chk("core_go", Core_Go, e_go);
    chk("proto_err", Proto_Err, e_err);
  endtask

  // One clock: DUT and model both sample the inputs driven at the last
  // negedge; outputs are checked at the following negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle_inputs();
    Start = 0; Core_Done = 0;
  endtask

  task automatic pulse_done();
    Core_Done = 1; cycle(); Core_Done = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        start;
    logic        done;
    logic        ready;
    logic        we;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic        r0we;
    logic        go;
  } vec_t;

  vec_t tbl[25];

  int r0_seen;

  initial begin
    // Task A: words 0..15, R0 0xABCD. Start at entry 0, writes at 1..16,
    // go at 17, WAIT from 18, Done 5 cycles into WAIT (entry 23),
    // back-to-back Start at entry 24.
    for (int i = 0; i < 25; i++) begin
      tbl[i].start = (i == 0) || (i == 24);
      tbl[i].done  = (i == 23);
      tbl[i].ready = (i == 23);
      tbl[i].we    = (i >= 1 && i <= 16);
      tbl[i].addr  = (i >= 1 && i <= 16) ? 4'(i - 1) : 4'h0;
      tbl[i].wdata = (i >= 1 && i <= 16) ? 16'(i - 1) : 16'h0;
      tbl[i].r0we  = (i == 1);
      tbl[i].go    = (i == 17);
    end

    reset = 0; Start = 0; Core_Done = 0; Insn_Data = '0;
    Init_R0_Vect = 0; Init_R0 = '0;
    e_ready = 1; e_we = 0; e_r0we = 0; e_go = 0; e_err = 0;
    e_addr = '0; e_wdata = '0; e_r0data = '0;

    // Reset held, then released with Start=0 for 10 cycles
    repeat (3) cycle();
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("rst_ready", Ready, 1);
      chk("rst_we", Imem_We, 0);
      chk("rst_go", Core_Go, 0);
    end

    // Table run
    Insn_Data = make_block(16'h0000); Init_R0_Vect = 1; Init_R0 = 16'hABCD;
    for (int i = 0; i < 25; i++) begin
      Start = tbl[i].start;
      Core_Done = tbl[i].done;
      if (i == 24) Insn_Data = make_block(16'h0100);
      cycle();
      chk("tbl_ready", Ready, tbl[i].ready);
      chk("tbl_we", Imem_We, tbl[i].we);
      if (tbl[i].we) begin
        chk("tbl_addr", Imem_Addr, tbl[i].addr);
        chk("tbl_wdata", Imem_Wdata, tbl[i].wdata);
      end
      chk("tbl_r0we", R0_We, tbl[i].r0we);
      if (tbl[i].r0we) chk("tbl_r0data", R0_Wdata, 16'hABCD);
      chk("tbl_go", Core_Go, tbl[i].go);
    end
    idle_inputs();

    // Second (back-to-back) block must be written exactly
    for (int i = 1; i <= 19; i++) begin
      cycle();
      if (i <= 16) begin
        chk("b2b_we", Imem_We, 1);
        chk("b2b_wdata", Imem_Wdata, 16'h0100 + 16'(i - 1));
      end
    end
    pulse_done();
    chk("b2b_done_ready", Ready, 1);

    // Same task without R0 initialisation
    Insn_Data = make_block(16'h0000); Init_R0_Vect = 0; Init_R0 = 16'hABCD;
    Start = 1; cycle(); Start = 0;
    r0_seen = 0;
    for (int i = 0; i < 19; i++) begin
      cycle();
      if (R0_We) r0_seen++;
    end
    chk("no_r0_we", r0_seen, 0);
    pulse_done();

    // Start pulsed while word 7 is being written
    Insn_Data = make_block(16'h0200); Init_R0_Vect = 1; Init_R0 = 16'h1234;
    Start = 1; cycle(); Start = 0;
    repeat (7) cycle();
    Insn_Data = make_block(16'h0F00); Init_R0 = 16'h5555;
    Start = 1; cycle(); Start = 0;
    chk("w7_addr", Imem_Addr, 7);
    cycle();
    chk("w8_data", Imem_Wdata, 16'h0208);
`ifdef TASK_RX_PROTO_CHECK_EN
    chk("proto_err_set", Proto_Err, 1);
`endif
    repeat (10) cycle();
    pulse_done();

    // Reset asserted while word 9 is being written
    Insn_Data = make_block(16'h0300); Init_R0_Vect = 0;
    Start = 1; cycle(); Start = 0;
    repeat (10) cycle();
    chk("pre_rst_addr", Imem_Addr, 9);
    reset = 0;
    cycle();
    chk("midrst_ready", Ready, 1);
    chk("midrst_we", Imem_We, 0);
    chk("midrst_err", Proto_Err, 0);
    reset = 1;
    Insn_Data = make_block(16'h0400);
    Start = 1; cycle(); Start = 0;
    cycle();
    chk("restart_we", Imem_We, 1);
    chk("restart_addr", Imem_Addr, 0);
    chk("restart_data", Imem_Wdata, 16'h0400);
    repeat (18) cycle();
    pulse_done();

    // Randomized traffic, including stray Start/Done and occasional reset
    for (int i = 0; i < 1500; i++) begin
      Start        = ($urandom_range(0, 5) == 0);
      Core_Done    = ($urandom_range(0, 4) == 0);
      Init_R0_Vect = 1'($urandom);
      Init_R0      = 16'($urandom);
      for (int w = 0; w < 8; w++) Insn_Data[32*w +: 32] = $urandom;
      reset        = ($urandom_range(0, 299) != 0);
      cycle();
    end
    reset = 1;
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
